ps2_rx: RTL and testbench

- PS/2 keyboard receive front end. Captures raw 11-bit frames from the PS/2 clock and data pins.
- Delivers each validated scan code on ps2_data, with a one-cycle ps2_hit strobe. These feed the port controller's ps2_data/ps2_hit inputs directly.
- Receive-only: no host-to-device transmission and no scan-code translation. Runs on the 25 MHz system clock.

---
 rtl/ps2_rx.sv | 98 +++++++++
 tb/tb_ps2_rx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver, filters the PS/2 clock and validates 11-bit frames into scan codes.
module ps2_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FILTER) + 1;
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_n;
  logic [1:0] cs, ds;
  logic fclk, fclk_d, fall, dat;
  logic [FW-1:0] fcnt;
  logic [3:0] bcnt, bcnt_n;
  logic [7:0] sr, sr_n, data_n;
  logic par, par_n, hit_n, err_n;
  logic [TW-1:0] tcnt, tcnt_n;
  assign dat  = ds[1];
  assign fall = fclk_d & ~fclk;
  assign busy = state == RECV;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cs     <= 2'b11;
      ds     <= 2'b11;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      cs     <= {cs[0], ps2_clk};
      ds     <= {ds[0], ps2_dat};
      fclk_d <= fclk;
      if (cs[1] == fclk) fcnt <= '0;
      else if (fcnt == FW'(FILTER - 1)) begin
        fclk <= cs[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= IDLE;
      bcnt     <= '0;
      sr       <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      ps2_data <= '0;
      ps2_hit  <= 1'b0;
      ps2_err  <= 1'b0;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt_n;
      sr       <= sr_n;
      par      <= par_n;
      tcnt     <= tcnt_n;
      ps2_data <= data_n;
      ps2_hit  <= hit_n;
      ps2_err  <= err_n;
    end
  // A falling edge always wins over the timeout limit in the same cycle.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sr_n    = sr;
    par_n   = par;
    tcnt_n  = tcnt;
    data_n  = ps2_data;
    hit_n   = 1'b0;
    err_n   = 1'b0;
    if (state == IDLE) begin
      if (fall && !dat) begin
        state_n = RECV;
        bcnt_n  = '0;
        tcnt_n  = '0;
      end
    end else if (fall) begin
      tcnt_n = '0;
      bcnt_n = bcnt + 1'b1;
      if (bcnt < 4'd8) sr_n = {dat, sr[7:1]};
      else if (bcnt == 4'd8) par_n = dat;
      else begin
        state_n = IDLE;
        hit_n   = ^{sr, par} & dat;
        err_n   = ~hit_n;
        data_n  = hit_n ? sr : ps2_data;
      end
    end else if (tcnt == TW'(TIMEOUT - 1)) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else tcnt_n = tcnt + 1'b1;
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames against ps2_rx with hand-computed scan codes and pulse counts.
module tb_ps2_rx;
  logic clock = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic ps2_hit, ps2_err, busy;
  int errors = 0, checks = 0, hits = 0, errs = 0, both = 0, h0, e0;

  ps2_rx dut (.clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
              .ps2_data(ps2_data), .ps2_hit(ps2_hit), .ps2_err(ps2_err), .busy(busy));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    hits += int'(ps2_hit);
    errs += int'(ps2_err);
    both += int'(ps2_hit & ps2_err);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // nb bits of the frame are sent; gl injects a 3-cycle clock glitch after that bit; lat checks pulse timing on the stop edge.
  task automatic send(input logic [7:0] d, input logic p, input int half, input int nb = 11,
                      input int gl = -1, input bit lat = 0);
    logic [10:0] f;
    f = {1'b1, p, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      ps2_dat = f[i];
      tick(half / 2);
      ps2_clk = 1'b0;
      if (lat && i == 10) begin
        tick(10);
        check("hit_early", ps2_hit, 0);
        tick(1);
        check("hit_n1", ps2_hit, 1);
        check("err_n1", ps2_err, 0);
        tick(1);
        check("hit_width", ps2_hit, 0);
        tick(half - 12);
      end else tick(half);
      ps2_clk = 1'b1;
      if (i == gl) begin
        tick(20);
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(half / 2 - 23);
      end else tick(half / 2);
    end
    ps2_dat = 1'b1;
  endtask

  initial begin
    tick(3);
    check("rst_data", ps2_data, 8'h00);
    check("rst_hit", ps2_hit, 0);
    check("rst_err", ps2_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(5);

    h0 = hits; e0 = errs;
    send(8'h1C, 1'b0, 1000, 11, -1, 1);
    tick(20);
    check("v1c_data", ps2_data, 8'h1C);
    check("v1c_hits", hits - h0, 1);
    check("v1c_errs", errs - e0, 0);
    check("v1c_busy", busy, 0);

    h0 = hits; e0 = errs;
    send(8'h1C, 1'b1, 100);
    tick(20);
    check("par_errs", errs - e0, 1);
    check("par_hits", hits - h0, 0);
    check("par_data", ps2_data, 8'h1C);

    h0 = hits; e0 = errs;
    send(8'h0F, 1'b0, 100, 5);
    check("to_busy_mid", busy, 1);
    tick(25100);
    check("to_errs", errs - e0, 1);
    check("to_busy", busy, 0);
    check("to_data", ps2_data, 8'h1C);
    h0 = hits; e0 = errs;
    send(8'hF0, 1'b1, 100);
    tick(20);
    check("f0_data", ps2_data, 8'hF0);
    check("f0_hits", hits - h0, 1);
    check("f0_errs", errs - e0, 0);

    h0 = hits; e0 = errs;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    check("gl_idle_busy", busy, 0);
    send(8'h5A, 1'b1, 100, 11, 3);
    tick(20);
    check("gl_data", ps2_data, 8'h5A);
    check("gl_hits", hits - h0, 1);
    check("gl_errs", errs - e0, 0);

    h0 = hits; e0 = errs;
    send(8'h29, 1'b0, 100, 4);
    check("rs_busy_mid", busy, 1);
    reset = 1'b1;
    #1;
    check("rs_data", ps2_data, 8'h00);
    check("rs_busy", busy, 0);
    tick(3);
    reset = 1'b0;
    tick(200);
    check("rs_hits", hits - h0, 0);
    check("rs_errs", errs - e0, 0);
    check("rs_hold", ps2_data, 8'h00);
    send(8'h29, 1'b0, 100);
    tick(20);
    check("v29_data", ps2_data, 8'h29);
    check("v29_hits", hits - h0, 1);

    h0 = hits; e0 = errs;
    send(8'hE0, 1'b0, 100);
    check("b2b_first", ps2_data, 8'hE0);
    send(8'h75, 1'b0, 100);
    tick(20);
    check("b2b_second", ps2_data, 8'h75);
    check("b2b_hits", hits - h0, 2);
    check("b2b_errs", errs - e0, 0);
    check("hit_err_overlap", both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
